// File: rtl/float_lzc_normalizer_pkg.sv
// Shared float helpers: default widths, a constant clog2 and the chunk-count
// computation used by the multi-cycle normalizer and its leading-zero counter.
package float_lzc_normalizer_pkg;

    localparam int DEF_MANT_WIDTH     = 48;
    localparam int DEF_EXP_WIDTH      = 10;
    localparam int DEF_SCAN_WIDTH     = 16;
    localparam int DEF_LZC_GROUP_SIZE = 4;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

    function automatic int num_chunks(input int mant_width, input int scan_width);
        return mant_width / scan_width;
    endfunction

endpackage

// File: rtl/float_lzc.sv
// Grouped leading-zero counter: finds the first nonzero GROUP_SIZE-bit group from
// the MSB, then the leading zeros inside it. Result = OUTPUT_BIAS + OUTPUT_STEP * lz.
module float_lzc
    import float_lzc_normalizer_pkg::*;
#(
    parameter int INPUT_WIDTH  = DEF_SCAN_WIDTH,
    parameter int OUTPUT_WIDTH = clog2(INPUT_WIDTH + 1),
    parameter int OUTPUT_STEP  = 1,
    parameter int OUTPUT_BIAS  = 0,
    parameter int GROUP_SIZE   = DEF_LZC_GROUP_SIZE
) (
    input  logic [INPUT_WIDTH-1:0]  lzc_in,
    output logic [OUTPUT_WIDTH-1:0] lzc_count,
    output logic                    lzc_zero
);

    localparam int NUM_GROUPS = INPUT_WIDTH / GROUP_SIZE;

    if (INPUT_WIDTH % GROUP_SIZE != 0) begin : g_bad_group
        $error("float_lzc: INPUT_WIDTH must be a multiple of GROUP_SIZE");
    end

    logic                  found;
    logic [GROUP_SIZE-1:0] grp;
    int                    group_lz;
    int                    count;

    always_comb begin
        found    = 1'b0;
        grp      = '0;
        group_lz = 0;
        count    = INPUT_WIDTH;
        for (int g = 0; g < NUM_GROUPS; g++) begin
            grp = lzc_in[INPUT_WIDTH-1-g*GROUP_SIZE -: GROUP_SIZE];
            if (!found && (grp != '0)) begin
                found = 1'b1;
                // Scanning LSB to MSB lets the highest set bit win.
                for (int b = 0; b < GROUP_SIZE; b++) begin
                    if (grp[b]) begin
                        group_lz = GROUP_SIZE - 1 - b;
                    end
                end
                count = g * GROUP_SIZE + group_lz;
            end
        end
        lzc_count = OUTPUT_WIDTH'(OUTPUT_BIAS + OUTPUT_STEP * count);
        lzc_zero  = !found;
    end

endmodule

// File: rtl/float_lzc_normalizer.sv
// Multi-cycle mantissa normalizer: shifts left until the MSB is set, scanning
// SCAN_WIDTH bits per cycle with one shared LZC, and adjusts the exponent to match.
module float_lzc_normalizer
    import float_lzc_normalizer_pkg::*;
#(
    parameter int MANT_WIDTH = DEF_MANT_WIDTH,
    parameter int EXP_WIDTH  = DEF_EXP_WIDTH,
    parameter int SCAN_WIDTH = DEF_SCAN_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [MANT_WIDTH-1:0] in_mant,
    input  logic [EXP_WIDTH-1:0]  in_exp,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [MANT_WIDTH-1:0] out_mant,
    output logic [EXP_WIDTH-1:0]  out_exp,
    output logic                  out_zero,
    output logic                  out_underflow
);

    localparam int NUM_CHUNKS = num_chunks(MANT_WIDTH, SCAN_WIDTH);
    localparam int CNT_W      = clog2(NUM_CHUNKS + 1);
    localparam int LZ_W       = clog2(SCAN_WIDTH + 1);
    localparam logic signed [EXP_WIDTH:0] SCAN_STEP = (EXP_WIDTH + 1)'(SCAN_WIDTH);

    if (MANT_WIDTH % SCAN_WIDTH != 0) begin : g_bad_scan
        $error("float_lzc_normalizer: MANT_WIDTH must be a multiple of SCAN_WIDTH");
    end

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t                   state_q, state_d;
    logic [MANT_WIDTH-1:0]    mant_q, mant_d;
    logic signed [EXP_WIDTH:0] exp_q, exp_d;
    logic [CNT_W-1:0]         chunk_cnt_q, chunk_cnt_d;
    logic                     zero_q, zero_d;

    logic [SCAN_WIDTH-1:0]    window;
    logic [LZ_W-1:0]          lz;
    logic                     window_zero;
    logic signed [EXP_WIDTH:0] lz_ext;

    assign window = mant_q[MANT_WIDTH-1 -: SCAN_WIDTH];
    assign lz_ext = signed'((EXP_WIDTH + 1)'(lz));

    float_lzc #(
        .INPUT_WIDTH (SCAN_WIDTH),
        .OUTPUT_WIDTH(LZ_W),
        .OUTPUT_STEP (1),
        .OUTPUT_BIAS (0)
    ) u_lzc (
        .lzc_in   (window),
        .lzc_count(lz),
        .lzc_zero (window_zero)
    );

    // Handshake: an input transfers on a rising edge where in_valid && in_ready;
    // an output transfers where out_valid && out_ready. in_ready is high only in
    // IDLE, and out_* hold steady while out_valid is high and out_ready is low.
    always_comb begin
        state_d     = state_q;
        mant_d      = mant_q;
        exp_d       = exp_q;
        chunk_cnt_d = chunk_cnt_q;
        zero_d      = zero_q;
        unique case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    mant_d      = in_mant;
                    exp_d       = {1'b0, in_exp};
                    chunk_cnt_d = '0;
                    zero_d      = 1'b0;
                    state_d     = ST_SCAN;
                end
            end
            ST_SCAN: begin
                if (!window_zero) begin
                    mant_d  = mant_q << lz;
                    exp_d   = exp_q - lz_ext;
                    state_d = ST_DONE;
                end else begin
                    mant_d      = mant_q << SCAN_WIDTH;
                    exp_d       = exp_q - SCAN_STEP;
                    chunk_cnt_d = chunk_cnt_q + 1'b1;
                    if (chunk_cnt_q == CNT_W'(NUM_CHUNKS - 1)) begin
                        zero_d  = 1'b1;
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            mant_q      <= '0;
            exp_q       <= '0;
            chunk_cnt_q <= '0;
            zero_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            mant_q      <= mant_d;
            exp_q       <= exp_d;
            chunk_cnt_q <= chunk_cnt_d;
            zero_q      <= zero_d;
        end
    end

    always_comb begin
        in_ready      = (state_q == ST_IDLE);
        out_valid     = (state_q == ST_DONE);
        out_mant      = mant_q;
        out_exp       = exp_q[EXP_WIDTH-1:0];
        out_zero      = 1'b0;
        out_underflow = 1'b0;
        if (zero_q) begin
            out_exp  = '0;
            out_zero = 1'b1;
        end else if (exp_q[EXP_WIDTH]) begin
            // Mantissa stays fully normalized; denormalizing happens downstream.
            out_exp       = '0;
            out_underflow = 1'b1;
        end
    end

endmodule
